instr_cache_refill: RTL and testbench

Line-fill engine that sits between the instruction cache and the instruction memory bus. On a cache miss it fetches one block-aligned line, one 32-bit word at a time, through a single-outstanding request/valid handshake. It assembles the words into the replacement block and holds replacement-ready until the cache set reports a hit. It drives the `RepBlock`/`RepReady` inputs of `instr_cache_set`.

---
 rtl/instr_cache_refill.sv | 91 +++++++++
 tb/tb_instr_cache_refill.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache_refill.sv
// rtl/instr_cache_refill.sv - instruction cache line-fill engine
// Fetches one block-aligned line word by word and holds it until the set consumes it.
module instr_cache_refill #(
  parameter int B = 64,
  parameter int A = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           CacheMiss,
  input  logic [A-1:0]   Addr,
  output logic           MemReq,
  output logic [A-1:0]   MemAddr,
  input  logic           MemValid,
  input  logic [31:0]    MemRData,
  output logic [B*8-1:0] RepBlock,
  output logic           RepReady,
  output logic           FillBusy
);

  localparam int W  = B / 4;
  localparam int OW = $clog2(B);
  localparam int CW = $clog2(W);
  localparam int TW = A - OW;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   ltag_q, ltag_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [B*8-1:0]  block_q;
  logic            tag_hit;
  logic            beat;

  assign tag_hit  = (Addr[A-1:OW] == ltag_q);
  assign MemAddr  = {ltag_q, cnt_q, 2'b00};
  assign RepBlock = block_q;
  assign FillBusy = (state_q == FILL);

  always_comb begin
    state_d  = state_q;
    ltag_d   = ltag_q;
    cnt_d    = cnt_q;
    MemReq   = 1'b0;
    RepReady = 1'b0;
    beat     = 1'b0;
    case (state_q)
      IDLE: begin
        if (CacheMiss) begin
          ltag_d  = Addr[A-1:OW];
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        MemReq = 1'b1;
        if (MemValid) begin
          beat  = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_d = DONE;
        end
      end
      DONE: begin
        RepReady = tag_hit;
        if (!CacheMiss) begin
          state_d = IDLE;
        end else if (!tag_hit) begin
          // Redirect to a different line: refetch rather than hand over a stale block.
          ltag_d  = Addr[A-1:OW];
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ltag_q  <= '0;
      cnt_q   <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      ltag_q  <= ltag_d;
      cnt_q   <= cnt_d;
      if (beat) block_q[{cnt_q, 5'b00000} +: 32] <= MemRData;
    end
  end

endmodule

// File: tb/tb_instr_cache_refill.sv
// tb/tb_instr_cache_refill.sv - self-checking bench for instr_cache_refill
// Memory returns MemAddr ^ 0xA5A5A5A5; expected request addresses live in a scoreboard queue.
module tb_instr_cache_refill;

  logic         clk = 1'b0;
  logic         clk_en = 1'b0;
  logic         reset;
  logic         cache_miss;
  logic [31:0]  addr;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_valid;
  logic [31:0]  mem_rdata;
  logic [511:0] rep_block;
  logic         rep_ready;
  logic         fill_busy;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        miss;
    logic [31:0] a;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        req;
  } vec_t;

  instr_cache_refill #(.B(64), .A(32)) dut (
    .clk(clk), .reset(reset), .CacheMiss(cache_miss), .Addr(addr),
    .MemReq(mem_req), .MemAddr(mem_addr), .MemValid(mem_valid), .MemRData(mem_rdata),
    .RepBlock(rep_block), .RepReady(rep_ready), .FillBusy(fill_busy)
  );

  assign mem_rdata = mem_addr ^ 32'hA5A5_A5A5;

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [511:0] line_of(input logic [31:0] a);
    logic [511:0] blk;
    logic [31:0]  base;
    base = a & ~32'h3F;
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = (base + 32'(4*i)) ^ 32'hA5A5_A5A5;
    return blk;
  endfunction

  task automatic push_line(input logic [31:0] a);
    for (int i = 0; i < 16; i++) exp_q.push_back((a & ~32'h3F) + 32'(4*i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_miss(input logic [31:0] a);
    cache_miss = 1'b1;
    addr = a;
    push_line(a);
    tick();
  endtask

  // Cycle n=1 is the cycle after the miss edge; returns the first cycle with RepReady high.
  task automatic run(input int period, input int redir_beats, input logic [31:0] raddr,
                     input int stop_beats, input int budget, output int ready_n, output int gap_n);
    int beats;
    beats = 0;
    ready_n = -1;
    gap_n = -1;
    for (int n = 1; n <= budget; n++) begin
      mem_valid = ((n % period) == 0);
      if (rep_ready) begin
        ready_n = n;
        break;
      end
      if (!mem_req && gap_n < 0) gap_n = n;
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got req at %0h want no request", mem_addr);
        end else begin
          chk("mem_addr", mem_addr, exp_q[0]);
          if (mem_valid) begin
            void'(exp_q.pop_front());
            beats++;
            if (beats == redir_beats) begin
              addr = raddr;
              push_line(raddr);
            end
          end
        end
      end
      tick();
      if (stop_beats > 0 && beats == stop_beats) begin
        ready_n = 0;
        break;
      end
    end
    if (ready_n < 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got no RepReady want it within %0d cycles", budget);
    end
  endtask

  vec_t vecs[14];
  int   rn, gn;

  initial begin
    reset = 1'b1;
    cache_miss = 1'b0;
    addr = 32'h0;
    mem_valid = 1'b1;

    // Reset with the clock stopped: outputs must settle to zero without an edge.
    #2;
    chk("rst_ctl", {mem_req, fill_busy, rep_ready}, 3'b000);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_block", rep_block, 512'h0);
    #1 reset = 1'b0;
    clk_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ctl", {mem_req, fill_busy, rep_ready}, 3'b000);
      chk("idle_block", rep_block, 512'h0);
    end

    // Zero-wait fill
    start_miss(32'h0000_1048);
    run(1, 0, 32'h0, 0, 40, rn, gn);
    chk("zw_ready_cycle", 32'(rn), 32'd17);
    chk("zw_word0", rep_block[31:0], 32'hA5A5_B5E5);
    chk("zw_word15", rep_block[511:480], 32'hA5A5_B5D9);
    chk("zw_block", rep_block, line_of(32'h1040));
    chk("zw_done_ctl", {mem_req, fill_busy}, 2'b00);
    cache_miss = 1'b0;
    tick();
    chk("zw_drop", {mem_req, fill_busy, rep_ready}, 3'b000);

    // Wait states: one beat every third cycle
    start_miss(32'h0000_1048);
    run(3, 0, 32'h0, 0, 120, rn, gn);
    chk("ws_ready_cycle", 32'(rn), 32'd49);
    chk("ws_block", rep_block, line_of(32'h1040));
    cache_miss = 1'b0;
    tick();

    // Redirect after 5 beats: first line still completes, then the new one
    start_miss(32'h0000_1048);
    run(1, 5, 32'h0000_2000, 0, 80, rn, gn);
    chk("rd_done_gap", 32'(gn), 32'd17);
    chk("rd_ready_cycle", 32'(rn), 32'd34);
    chk("rd_block", rep_block, line_of(32'h2000));
    cache_miss = 1'b0;
    tick();

    // Reset mid-fill after 7 beats
    start_miss(32'h0000_1040);
    run(1, 0, 32'h0, 7, 40, rn, gn);
    chk("mf_busy", fill_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mf_rst_ctl", {mem_req, fill_busy, rep_ready}, 3'b000);
    chk("mf_rst_addr", mem_addr, 32'h0);
    chk("mf_rst_block", rep_block, 512'h0);
    exp_q.delete();
    #1 reset = 1'b0;
    start_miss(32'h0000_1040);
    run(1, 0, 32'h0, 0, 40, rn, gn);
    chk("mf_ready_cycle", 32'(rn), 32'd17);
    chk("mf_block", rep_block, line_of(32'h1040));

    // Held ready in DONE, then spurious valids in DONE and IDLE
    for (int i = 0; i < 10; i++) vecs[i] = '{1'b1, 32'h1044 + 32'(i), 1'(i % 2), 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h1040, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 11; i < 14; i++) vecs[i] = '{1'b0, 32'h1040, 1'(i % 2), 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      cache_miss = vecs[i].miss;
      addr = vecs[i].a;
      mem_valid = vecs[i].valid;
      #1;
      chk($sformatf("vec%0d_ctl", i), {rep_ready, fill_busy, mem_req},
          {vecs[i].ready, vecs[i].busy, vecs[i].req});
      tick();
    end
    chk("hold_block", rep_block, line_of(32'h1040));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
